seq_mul_recon: RTL and testbench

//  Sequential unsigned shift-add multiplier that computes RESULT = A*B + C.
//  It is the reconstruction side of the array divider datapath: feeding it

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_addstep.sv | 28 ++
 rtl/seq_mul_recon.sv | 104 ++++++++++
 tb/tb_seq_mul_recon.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential multiply-add datapath.
//   MUL_W   : default operand width
//   ST_*    : FSM state encodings
//   state_e : FSM state type built from the encodings
package mul_pkg;

    localparam int unsigned MUL_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/mul_addstep.sv
// One shift-add step: conditionally add the multiplicand into the upper
// accumulator half, keeping the carry out in the extra sum bit.
//   i_acc_hi : upper half of the product register (W bits)
//   i_mcand  : multiplicand (W bits)
//   i_sel    : current multiplier LSB; selects whether mcand is added
//   o_sum    : W+1 bit sum, MSB is the carry shifted back into the register
module mul_addstep
    import mul_pkg::*;
#(
    parameter int unsigned W = MUL_W
) (
    input  logic [W-1:0] i_acc_hi,
    input  logic [W-1:0] i_mcand,
    input  logic         i_sel,
    output logic [W:0]   o_sum
);

    logic [W:0] w_addend;

    always_comb begin
        w_addend = '0;
        if (i_sel) begin
            w_addend = {1'b0, i_mcand};
        end
        o_sum = {1'b0, i_acc_hi} + w_addend;
    end

endmodule

// File: rtl/seq_mul_recon.sv
// Sequential unsigned shift-add multiplier computing result = a*b + c.
// Used to rebuild a dividend from quotient, divisor and remainder.
//   clk, rst_n               : clock, async active-low reset
//   start_valid/start_ready  : command handshake, a/b/c sampled on fire
//   a, b, c                  : multiplicand, multiplier, addend (W bits)
//   busy                     : high while an operation is in flight or held
//   res_valid/res_ready      : result handshake
//   result                   : a*b + c (2W bits), stable while res_valid
module seq_mul_recon
    import mul_pkg::*;
#(
    parameter int unsigned W = MUL_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    output logic           busy,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] result
);

    localparam int unsigned CW = $clog2(W) + 1;
    localparam int unsigned PW = 2 * W;

    state_e           r_state;
    logic [W-1:0]     r_mcand;
    logic [W-1:0]     r_addend;
    // Product register: upper half accumulates, lower half holds the
    // multiplier bits still to be consumed and fills with product bits.
    logic [PW-1:0]    r_prod;
    logic [CW-1:0]    r_cnt;

    logic [W:0]       w_sum;
    logic [PW-1:0]    w_prod_next;

    mul_addstep #(.W(W)) u_addstep (
        .i_acc_hi (r_prod[PW-1:W]),
        .i_mcand  (r_mcand),
        .i_sel    (r_prod[0]),
        .o_sum    (w_sum)
    );

    // Carry re-enters at the top as the register shifts right by one.
    assign w_prod_next = {w_sum, r_prod[W-1:1]};

    // FSM, datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_addend    <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            result      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_mcand     <= a;
                        r_addend    <= c;
                        r_prod      <= {W'(0), b};
                        r_cnt       <= CW'(W - 1);
                        r_state     <= RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt - CW'(1);
                    // Last step: fold in the addend; cannot overflow 2W bits.
                    if (r_cnt == '0) begin
                        result    <= w_prod_next + PW'(r_addend);
                        r_state   <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_recon.sv
// Self-checking bench for seq_mul_recon (W=6): directed vector table,
// backpressure and mid-run reset sequences, and a random sweep.
module tb_seq_mul_recon;

    localparam int unsigned W  = 6;
    localparam int unsigned PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] result;

    int errors = 0;
    int checks = 0;

    seq_mul_recon #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .c           (c),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  c;
        logic [PW-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command and collect its result. All driving and sampling
    // happens on falling edges. lat counts cycles from the handshake edge.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input int ready_gap,
                         output logic [PW-1:0] res, output int lat);
        int n;
        @(negedge clk);
        start_valid = 1'b1;
        a = ia; b = ib; c = ic;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) chk("start_timeout", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 50) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!res_valid) chk("result_timeout", 32'(res_valid), 32'd1);
        res = result;
        for (int i = 0; i < ready_gap; i++) begin
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("rv_drop", 32'(res_valid), 32'd0);
        chk("ready_back", 32'(start_ready), 32'd1);
    endtask

    vec_t          vecs[7];
    logic [PW-1:0] res;
    int            lat;

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = '0; b = '0; c = '0;

        vecs[0] = '{a: 6'd7,  b: 6'd6,  c: 6'd3,  exp: 12'd45};
        vecs[1] = '{a: 6'd63, b: 6'd63, c: 6'd63, exp: 12'd4032};
        vecs[2] = '{a: 6'd0,  b: 6'd41, c: 6'd17, exp: 12'd17};
        vecs[3] = '{a: 6'd1,  b: 6'd1,  c: 6'd0,  exp: 12'd1};
        vecs[4] = '{a: 6'd0,  b: 6'd0,  c: 6'd0,  exp: 12'd0};
        vecs[5] = '{a: 6'd41, b: 6'd0,  c: 6'd9,  exp: 12'd9};
        vecs[6] = '{a: 6'd5,  b: 6'd9,  c: 6'd2,  exp: 12'd47};

        repeat (3) @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold_valid", 32'(res_valid), 32'd0);
        chk("idle_hold_ready", 32'(start_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, i % 3, res, lat);
            chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
        end

        // Backpressure: result held, second command ignored until IDLE
        @(negedge clk);
        start_valid = 1'b1;
        a = 6'd7; b = 6'd6; c = 6'd3;
        @(negedge clk);
        start_valid = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        chk("bp_valid", 32'(res_valid), 32'd1);
        start_valid = 1'b1;
        a = 6'd2; b = 6'd3; c = 6'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result_stable", 32'(result), 32'd45);
            chk("bp_valid_held", 32'(res_valid), 32'd1);
            chk("bp_start_ready_low", 32'(start_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_idle_valid", 32'(res_valid), 32'd0);
        chk("bp_idle_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b0;
        chk("bp_second_accepted", 32'(busy), 32'd1);
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        chk("bp_second_result", 32'(result), 32'd10);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Async reset in the middle of RUN
        start_valid = 1'b1;
        a = 6'd7; b = 6'd6; c = 6'd3;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_ready", 32'(start_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(6'd5, 6'd9, 6'd2, 0, res, lat);
        chk("post_rst_result", 32'(res), 32'd47);
        chk("post_rst_latency", 32'(lat), 32'(W + 1));

        // Random sweep with random gaps on both sides
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0]  ra, rb, rc;
            logic [PW-1:0] exp;
            ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
            exp = PW'(ra) * PW'(rb) + PW'(rc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(ra, rb, rc, int'($urandom_range(0, 3)), res, lat);
            chk($sformatf("rand%0d", i), 32'(res), 32'(exp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
